// File: rtl/timer_game_pkg.sv
// ============================================================================
// Module  : timer_game_pkg
// Brief   : Shared state encoding and digit/guard bounds for the timer game.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package timer_game_pkg;

    typedef enum logic [2:0] {
        EDIT  = 3'd0,
        LOAD  = 3'd1,
        START = 3'd2,
        RUN   = 3'd3,
        BOOM  = 3'd4,
        SAFE  = 3'd5
    } state_e;

    localparam int MAX_TEN = 9;
    localparam int MAX_ONE = 9;
    localparam int GUARD_W = 4;

endpackage

`default_nettype wire

// File: rtl/bcd_digit_adj.sv
// ============================================================================
// Module  : bcd_digit_adj
// Brief   : Combinational BCD digit step with wrap-around and force-to-zero.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module bcd_digit_adj
    import timer_game_pkg::*;
#(
    parameter int MAX = MAX_ONE
) (
    input  logic [3:0] digit_i,
    input  logic       up_i,
    input  logic       down_i,
    input  logic       lockZero_i,
    output logic [3:0] digit_o
);

    always_comb begin
        digit_o = digit_i;
        if (lockZero_i) begin
            digit_o = 4'd0;
        end else if (up_i) begin
            digit_o = (digit_i >= 4'(MAX)) ? 4'd0 : digit_i + 4'd1;
        end else if (down_i) begin
            digit_o = (digit_i == 4'd0) ? 4'(MAX) : digit_i - 4'd1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/timer_setup_ctrl.sv
// ============================================================================
// Module  : timer_setup_ctrl
// Brief   : Digit entry, timer load/start and outcome latch for the bomb timer.
//           Optional edit blink enabled by macro TIMER_SETUP_BLINK_EN.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module timer_setup_ctrl
    import timer_game_pkg::*;
#(
    parameter int DEFAULT_TEN  = 3,
    parameter int DEFAULT_ONE  = 0,
    parameter int GUARD_CYCLES = 2,
    parameter int BLINK_DIV    = 50000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btnUp,
    input  logic       btnDown,
    input  logic       btnSel,
    input  logic       btnArm,
    input  logic       btnAbort,
    input  logic       defuse,
    input  logic       timeOutCTRL,
    output logic [3:0] userDigitTEN,
    output logic [3:0] userDigitONE,
    output logic       timerReconfigTEN_ONE,
    output logic       enable,
    output logic       editSel,
    output logic       armed,
    output logic       exploded,
    output logic       defused,
    output logic [1:0] blinkMask
);

    localparam logic [3:0]         RST_TEN    = 4'(DEFAULT_TEN);
    localparam logic [3:0]         RST_ONE    = (DEFAULT_TEN == MAX_TEN) ? 4'd0 : 4'(DEFAULT_ONE);
    localparam logic [GUARD_W-1:0] GUARD_LOAD = GUARD_W'(GUARD_CYCLES);

    state_e             state_q, state_d;
    logic [3:0]         ten_q, ten_d;
    logic [3:0]         one_q, one_d;
    logic               sel_q, sel_d;
    logic [GUARD_W-1:0] guard_q, guard_d;
    logic               edit_up, edit_down;
    logic               ten_up, ten_down, one_up, one_down;
    logic               reconfig_q, enable_q, armed_q, exploded_q, defused_q;

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        edit_up   = 1'b0;
        edit_down = 1'b0;
        case (state_q)
            EDIT: begin
                if (btnAbort) begin
                    sel_d = 1'b0;
                end else if (btnArm) begin
                    if ((ten_q != 4'd0) || (one_q != 4'd0)) begin
                        state_d = LOAD;
                    end
                end else if (btnSel) begin
                    sel_d = ~sel_q;
                end else if (btnUp) begin
                    edit_up = 1'b1;
                end else if (btnDown) begin
                    edit_down = 1'b1;
                end
            end
            LOAD, START: begin
                if (btnAbort) begin
                    state_d = EDIT;
                    sel_d   = 1'b0;
                end else begin
                    state_d = (state_q == LOAD) ? START : RUN;
                end
            end
            RUN: begin
                if (btnAbort) begin
                    state_d = EDIT;
                    sel_d   = 1'b0;
                end else if (defuse) begin
                    state_d = SAFE;
                end else if (timeOutCTRL && (guard_q == '0)) begin
                    state_d = BOOM;
                end
            end
            BOOM, SAFE: begin
                if (btnAbort) begin
                    state_d = EDIT;
                    sel_d   = 1'b0;
                end
            end
            default: begin
                state_d = EDIT;
                sel_d   = 1'b0;
            end
        endcase
    end

    // The timer's timeout is stale for a few cycles after enable rises.
    always_comb begin
        guard_d = guard_q;
        if ((state_d == RUN) && (state_q != RUN)) begin
            guard_d = GUARD_LOAD;
        end else if (guard_q != '0) begin
            guard_d = guard_q - GUARD_W'(1);
        end
    end

    assign ten_up   = edit_up   & ~sel_q;
    assign ten_down = edit_down & ~sel_q;
    assign one_up   = edit_up   &  sel_q & (ten_q != 4'(MAX_TEN));
    assign one_down = edit_down &  sel_q & (ten_q != 4'(MAX_TEN));

    bcd_digit_adj #(.MAX(MAX_TEN)) u_ten_adj (
        .digit_i    (ten_q),
        .up_i       (ten_up),
        .down_i     (ten_down),
        .lockZero_i (1'b0),
        .digit_o    (ten_d)
    );

    // Forcing ones to zero whenever tens is 9 keeps 91-99 unreachable.
    bcd_digit_adj #(.MAX(MAX_ONE)) u_one_adj (
        .digit_i    (one_q),
        .up_i       (one_up),
        .down_i     (one_down),
        .lockZero_i (ten_d == 4'(MAX_TEN)),
        .digit_o    (one_d)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= EDIT;
            ten_q      <= RST_TEN;
            one_q      <= RST_ONE;
            sel_q      <= 1'b0;
            guard_q    <= '0;
            reconfig_q <= 1'b0;
            enable_q   <= 1'b0;
            armed_q    <= 1'b0;
            exploded_q <= 1'b0;
            defused_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ten_q      <= ten_d;
            one_q      <= one_d;
            sel_q      <= sel_d;
            guard_q    <= guard_d;
            reconfig_q <= (state_d == LOAD);
            enable_q   <= (state_d == START) || (state_d == RUN);
            armed_q    <= (state_d == RUN);
            exploded_q <= (state_d == BOOM);
            defused_q  <= (state_d == SAFE);
        end
    end

    assign userDigitTEN         = ten_q;
    assign userDigitONE         = one_q;
    assign editSel              = sel_q;
    assign timerReconfigTEN_ONE = reconfig_q;
    assign enable               = enable_q;
    assign armed                = armed_q;
    assign exploded             = exploded_q;
    assign defused              = defused_q;

`ifdef TIMER_SETUP_BLINK_EN
    localparam int BLINK_W = $clog2(BLINK_DIV + 1);

    logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
    logic               phase_q, phase_d;
    logic [1:0]         blink_q;

    // Restart the phase on edits so the changed digit shows at once.
    always_comb begin
        blink_cnt_d = blink_cnt_q + BLINK_W'(1);
        phase_d     = phase_q;
        if (btnUp || btnDown) begin
            blink_cnt_d = '0;
            phase_d     = 1'b0;
        end else if (blink_cnt_q == BLINK_W'(BLINK_DIV - 1)) begin
            blink_cnt_d = '0;
            phase_d     = ~phase_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            blink_cnt_q <= '0;
            phase_q     <= 1'b0;
            blink_q     <= 2'b00;
        end else begin
            blink_cnt_q <= blink_cnt_d;
            phase_q     <= phase_d;
            blink_q     <= (state_d != EDIT) ? 2'b00 :
                           (sel_d ? {1'b0, phase_d} : {phase_d, 1'b0});
        end
    end

    assign blinkMask = blink_q;
`else
    assign blinkMask = {2{BLINK_DIV < 0}};
`endif

endmodule

`default_nettype wire

// File: tb/tb_timer_setup_ctrl.sv
// ============================================================================
// Module  : tb_timer_setup_ctrl
// Brief   : Directed plus random bench for timer_setup_ctrl against a digit/mode model.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_timer_setup_ctrl;

    localparam int GUARD = 2;
    localparam int M_EDIT = 0, M_LOAD = 1, M_START = 2, M_RUN = 3, M_BOOM = 4, M_SAFE = 5;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btnUp = 1'b0, btnDown = 1'b0, btnSel = 1'b0, btnArm = 1'b0, btnAbort = 1'b0;
    logic       defuse = 1'b0, timeOutCTRL = 1'b0;
    logic [3:0] userDigitTEN, userDigitONE;
    logic       timerReconfigTEN_ONE, enable, editSel, armed, exploded, defused;
    logic [1:0] blinkMask;

    int checks = 0;
    int errors = 0;

    // Model: digits as plain numbers, mode, and cycles spent in RUN.
    int m_ten, m_one, m_sel, m_mode, m_run_idx;

    timer_setup_ctrl dut (
        .clk                  (clk),
        .rst                  (rst),
        .btnUp                (btnUp),
        .btnDown              (btnDown),
        .btnSel               (btnSel),
        .btnArm               (btnArm),
        .btnAbort             (btnAbort),
        .defuse               (defuse),
        .timeOutCTRL          (timeOutCTRL),
        .userDigitTEN         (userDigitTEN),
        .userDigitONE         (userDigitONE),
        .timerReconfigTEN_ONE (timerReconfigTEN_ONE),
        .enable               (enable),
        .editSel              (editSel),
        .armed                (armed),
        .exploded             (exploded),
        .defused              (defused),
        .blinkMask            (blinkMask)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        int nm;
        nm = m_mode;
        if (rst) begin
            m_mode = M_EDIT; m_ten = 3; m_one = 0; m_sel = 0; m_run_idx = 0;
            return;
        end
        case (m_mode)
            M_EDIT: begin
                if (btnAbort) m_sel = 0;
                else if (btnArm) begin
                    if (m_ten * 10 + m_one > 0) nm = M_LOAD;
                end else if (btnSel) m_sel = 1 - m_sel;
                else if (btnUp) begin
                    if (m_sel == 0) begin
                        m_ten = (m_ten + 1) % 10;
                        if (m_ten == 9) m_one = 0;
                    end else if (m_ten != 9) m_one = (m_one + 1) % 10;
                end else if (btnDown) begin
                    if (m_sel == 0) begin
                        m_ten = (m_ten + 9) % 10;
                        if (m_ten == 9) m_one = 0;
                    end else if (m_ten != 9) m_one = (m_one + 9) % 10;
                end
            end
            M_LOAD, M_START: begin
                if (btnAbort) begin nm = M_EDIT; m_sel = 0; end
                else nm = m_mode + 1;
            end
            M_RUN: begin
                if (btnAbort) begin nm = M_EDIT; m_sel = 0; end
                else if (defuse) nm = M_SAFE;
                else if (timeOutCTRL && m_run_idx >= GUARD) nm = M_BOOM;
                else m_run_idx++;
            end
            default: begin
                if (btnAbort) begin nm = M_EDIT; m_sel = 0; end
            end
        endcase
        if (nm == M_RUN && m_mode != M_RUN) m_run_idx = 0;
        m_mode = nm;
    endtask

    always @(posedge clk) begin
        model_step();
        #1;
        chk("userDigitTEN", userDigitTEN, m_ten);
        chk("userDigitONE", userDigitONE, m_one);
        chk("editSel", editSel, m_sel);
        chk("reconfig", timerReconfigTEN_ONE, m_mode == M_LOAD);
        chk("enable", enable, (m_mode == M_START) || (m_mode == M_RUN));
        chk("armed", armed, m_mode == M_RUN);
        chk("exploded", exploded, m_mode == M_BOOM);
        chk("defused", defused, m_mode == M_SAFE);
        chk("blinkMask", blinkMask, 0);
        chk("value_le_90", (userDigitTEN * 10 + userDigitONE) <= 90, 1);
    end

    task automatic tick();
        @(posedge clk);
        #2;
        btnUp = 1'b0; btnDown = 1'b0; btnSel = 1'b0; btnArm = 1'b0; btnAbort = 1'b0; defuse = 1'b0;
    endtask

    initial begin
        repeat (2) tick();
        rst = 1'b0;
        chk("lit_rst_ten", userDigitTEN, 3);
        chk("lit_rst_one", userDigitONE, 0);
        chk("lit_rst_enable", enable, 0);

        btnUp = 1; tick(); btnUp = 1; tick();
        chk("lit_up2_ten", userDigitTEN, 5);
        btnSel = 1; tick(); btnDown = 1; tick();
        chk("lit_59", userDigitTEN * 10 + userDigitONE, 59);

        btnDown = 1; tick(); btnDown = 1; tick();
        btnSel = 1; tick();
        repeat (3) begin btnUp = 1; tick(); end
        chk("lit_87", userDigitTEN * 10 + userDigitONE, 87);
        btnUp = 1; tick();
        chk("lit_90", userDigitTEN * 10 + userDigitONE, 90);
        btnSel = 1; tick(); btnUp = 1; tick();
        chk("lit_90_ones_locked", userDigitONE, 0);
        btnSel = 1; tick(); btnDown = 1; tick();
        chk("lit_80", userDigitTEN * 10 + userDigitONE, 80);

        repeat (8) begin btnDown = 1; tick(); end
        btnArm = 1; tick();
        chk("lit_arm00_reconfig", timerReconfigTEN_ONE, 0);
        tick();
        chk("lit_arm00_enable", enable, 0);
        btnSel = 1; tick(); btnUp = 1; tick();
        chk("lit_01", userDigitTEN * 10 + userDigitONE, 1);
        timeOutCTRL = 1;
        btnArm = 1; tick();
        chk("lit_load_reconfig", timerReconfigTEN_ONE, 1);
        chk("lit_load_enable", enable, 0);
        tick();
        chk("lit_start_reconfig", timerReconfigTEN_ONE, 0);
        chk("lit_start_enable", enable, 1);
        chk("lit_start_armed", armed, 0);
        tick();
        chk("lit_run_armed", armed, 1);
        tick(); chk("lit_guard1", exploded, 0);
        tick(); chk("lit_guard2", exploded, 0);
        tick();
        chk("lit_boom", exploded, 1);
        chk("lit_boom_enable", enable, 0);
        btnAbort = 1; tick();
        chk("lit_abort_exploded", exploded, 0);
        chk("lit_abort_value", userDigitTEN * 10 + userDigitONE, 1);
        chk("lit_abort_sel", editSel, 0);

        timeOutCTRL = 0;
        btnArm = 1; tick();
        repeat (4) tick();
        defuse = 1; timeOutCTRL = 1; tick();
        chk("lit_safe_defused", defused, 1);
        chk("lit_safe_exploded", exploded, 0);
        chk("lit_safe_enable", enable, 0);
        timeOutCTRL = 0;
        btnAbort = 1; tick();

        btnAbort = 1; btnArm = 1; tick();
        chk("lit_abort_arm_reconfig", timerReconfigTEN_ONE, 0);
        tick();
        chk("lit_abort_arm_enable", enable, 0);
        btnArm = 1; tick(); tick(); tick();
        chk("lit_rerun_armed", armed, 1);
        rst = 1; tick(); rst = 0;
        chk("lit_rst_run_enable", enable, 0);
        chk("lit_rst_run_value", userDigitTEN * 10 + userDigitONE, 30);

        for (int i = 0; i < 4000; i++) begin
            rst         = ($urandom % 300) == 0;
            btnUp       = ($urandom % 4) == 0;
            btnDown     = ($urandom % 5) == 0;
            btnSel      = ($urandom % 6) == 0;
            btnArm      = ($urandom % 12) == 0;
            btnAbort    = ($urandom % 25) == 0;
            defuse      = ($urandom % 20) == 0;
            timeOutCTRL = ($urandom % 4) == 0;
            tick();
        end
        rst = 0; timeOutCTRL = 0;
        repeat (2) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/timer_setup_ctrl.md
Name: timer_setup_ctrl

Overview:
Upstream control stage for the two-digit countdown timer (0-90 s).
- Lets the player dial in the tens and ones digits with shaped button pulses.
- Loads the digits into the timer with a one-cycle reconfigure pulse, then drives the timer's enable.
- Watches the timer's timeout signal and holds the game outcome (exploded or defused) until the player aborts or reset is asserted.

Parameters:
- DEFAULT_TEN, 3, tens digit after reset (0-9).
- DEFAULT_ONE, 0, ones digit after reset (0-9; forced to 0 if DEFAULT_TEN=9).
- GUARD_CYCLES, 2, cycles after enable rises during which timeOutCTRL is ignored (1-15).
- BLINK_DIV, 50000000, clk cycles per blink half-period (used only with BLINK_EN).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- btnUp  in  1  single-cycle pulse: increment the selected digit
- btnDown  in  1  single-cycle pulse: decrement the selected digit
- btnSel  in  1  single-cycle pulse: toggle the selected digit (tens/ones)
- btnArm  in  1  single-cycle pulse: load and start the timer
- btnAbort  in  1  single-cycle pulse: stop and return to edit
- defuse  in  1  single-cycle pulse from the puzzle logic: bomb defused
- timeOutCTRL  in  1  timeout from the digit timer (high when enable is low or the count has expired)
- userDigitTEN  out  4  tens digit to the timer (BCD 0-9)
- userDigitONE  out  4  ones digit to the timer (BCD 0-9)
- timerReconfigTEN_ONE  out  1  one-cycle load pulse to the timer
- enable  out  1  timer run enable
- editSel  out  1  0 = tens selected, 1 = ones selected
- armed  out  1  high in state RUN
- exploded  out  1  high in state BOOM
- defused  out  1  high in state SAFE
- blinkMask  out  2  [1] blanks tens, [0] blanks ones (BLINK_EN only)

Behaviour:
- Clock and reset:
  - One clock, clk. Reset rst is synchronous and active-high.
  - Reset values: state=EDIT, digits=DEFAULT_TEN/DEFAULT_ONE, editSel=0, timerReconfigTEN_ONE=0, enable=0, armed=0, exploded=0, defused=0, blinkMask=00.
  - Reset wins over everything, in any state.
- States: EDIT, LOAD, START, RUN, BOOM, SAFE. All outputs are registered.
- Button priority when several pulses arrive in the same cycle: btnAbort > btnArm > btnSel > btnUp > btnDown. Exactly one action is taken per cycle.
- EDIT:
  - btnSel toggles editSel.
  - btnUp, tens: 9 wraps to 0, otherwise +1. If the new tens value is 9, ones is forced to 0 in the same cycle.
  - btnDown, tens: 0 wraps to 9 (ones forced to 0), otherwise -1.
  - btnUp, ones: if tens=9, no change; else 9 wraps to 0, otherwise +1.
  - btnDown, ones: if tens=9, no change; else 0 wraps to 9, otherwise -1.
  - Invariant: the value 91-99 is never produced.
  - btnArm with digits = 00 is ignored; the state stays EDIT.
  - btnArm with a nonzero value goes to LOAD.
- LOAD (1 cycle): timerReconfigTEN_ONE=1; go to START.
- START (1 cycle): reconfigure pulse low; enable=1 is registered; go to RUN.
- RUN:
  - enable=1 and armed=1; the guard counter is loaded with GUARD_CYCLES on entry.
  - timeOutCTRL is ignored while the guard counter is nonzero; the counter decrements each cycle.
  - After the guard expires, timeOutCTRL=1 goes to BOOM.
  - defuse=1 goes to SAFE. defuse beats timeout in the same cycle.
  - btnAbort goes to EDIT.
  - All other buttons are ignored.
- BOOM: enable=0, exploded=1. btnAbort goes to EDIT.
- SAFE: enable=0, defused=1. The timer count freezes, showing the remaining time. btnAbort goes to EDIT.
- Returning to EDIT keeps the last user digits and sets editSel=0.
- btnAbort in EDIT, LOAD or START goes to EDIT with enable=0 and no reconfigure pulse.
- Digits are frozen outside EDIT.

Optional Feature:
- Macro: TIMER_SETUP_BLINK_EN.
- Defined:
  - A free-running counter toggles a blink phase every BLINK_DIV cycles.
  - In EDIT, the blinkMask bit for the selected digit equals the phase; the other bit is 0.
  - In all other states blinkMask=00.
  - The phase counter resets to 0 on any btnUp or btnDown, so the digit is visible immediately.
- Not defined: blinkMask is tied to 2'b00 and no counter is synthesised.

Decomposition:
- Package timer_game_pkg holds:
  - the state encoding constants (EDIT=0, LOAD=1, START=2, RUN=3, BOOM=4, SAFE=5);
  - the bounds MAX_TEN=9 and MAX_ONE=9;
  - GUARD_W=4.
- Sub-module bcd_digit_adj is combinational.
  - Inputs: digit, up, down, lockZero.
  - Output: next digit, with the wrap rules above; lockZero forces 0.
  - One instance each for tens and ones.

Test Plan:
- Reset, then btnUp x2 on tens -> userDigitTEN=5, userDigitONE=0; btnSel, btnDown -> ones=9 (value 59).
- Tens=8, ones=7; btnUp on tens -> tens=9, ones=0 in the same cycle; btnSel, btnUp -> ones stays 0; btnDown on tens -> 8, ones stays 0.
- Digits 00, btnArm -> remains EDIT, no reconfigure pulse; set 01, btnArm -> reconfigure pulse exactly 1 cycle, enable rises the cycle after, armed the cycle after that.
- RUN with timeOutCTRL held 1 from entry -> no BOOM for GUARD_CYCLES=2 cycles, then exploded=1 and enable=0 one cycle later; btnAbort -> EDIT with digits unchanged.
- RUN, defuse and timeOutCTRL asserted in the same cycle after the guard -> SAFE, defused=1, exploded=0.
- btnAbort and btnArm in the same cycle in EDIT -> stays EDIT, no load; rst asserted during RUN -> next cycle enable=0, digits=30.
